// File: rtl/gate_preactivation_mac.sv
// ============================================================================
// gate_preactivation_mac : streaming MAC for z = bias + sum(w_i*x_i), floored
// and saturated to BITWIDTH-bit fixed point.                    Revision: 1.0
// ============================================================================
`default_nettype none

module gate_preactivation_mac #(
  parameter int BITWIDTH  = 18,
  parameter int FRAC_BITS = 12,
  parameter int NUM_ELEMS = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic signed [BITWIDTH-1:0] bias,
  input  logic                       elem_valid,
  input  logic signed [BITWIDTH-1:0] weight,
  input  logic signed [BITWIDTH-1:0] operand_x,
  output logic                       busy,
  output logic signed [BITWIDTH-1:0] result,
  output logic                       result_valid
);

  localparam int c_cnt_w  = $clog2(NUM_ELEMS + 1);
  localparam int c_prod_w = 2 * BITWIDTH;
  localparam int c_acc_w  = c_prod_w + c_cnt_w;

  localparam logic signed [c_acc_w-1:0] c_sat_max =
    {{(c_acc_w-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [c_acc_w-1:0] c_sat_min =
    {{(c_acc_w-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};
  localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(NUM_ELEMS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [c_cnt_w-1:0]           count_q, count_d;
  logic                         drain_q, drain_d;
  logic signed [c_prod_w-1:0]   prod_q, prod_d;
  logic                         prod_valid_q, prod_valid_d;
  logic signed [c_acc_w-1:0]    acc_q, acc_d;
  logic signed [BITWIDTH-1:0]   result_q, result_d;
  logic                         result_valid_q, result_valid_d;

  logic                         start_ok;
  logic                         elem_ok;
  logic signed [c_acc_w-1:0]    acc_shr;
  logic signed [BITWIDTH-1:0]   sat_val;

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign elem_ok  = elem_valid && (state_q == S_ACCUM);

  // Arithmetic shift floors toward -inf; no rounding is applied.
  assign acc_shr = acc_q >>> FRAC_BITS;

  always_comb begin
    sat_val = acc_shr[BITWIDTH-1:0];
    if (acc_shr > c_sat_max) begin
      sat_val = c_sat_max[BITWIDTH-1:0];
    end else if (acc_shr < c_sat_min) begin
      sat_val = c_sat_min[BITWIDTH-1:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    drain_d        = drain_q;
    prod_d         = prod_q;
    prod_valid_d   = 1'b0;
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = 1'b0;

    if (prod_valid_q) begin
      acc_d = acc_q + c_acc_w'(prod_q);
    end

    if (elem_ok) begin
      prod_d       = c_prod_w'(weight) * c_prod_w'(operand_x);
      prod_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (elem_ok) begin
          if (count_q == c_last_idx) begin
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_DONE;
        else         drain_d = 1'b1;
      end
      S_DONE: begin
        result_d       = sat_val;
        result_valid_d = 1'b1;
        state_d        = start_ok ? S_ACCUM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bias is pre-scaled by FRAC_BITS so it lines up with the product LSB.
    if (start_ok) begin
      acc_d   = c_acc_w'(bias) <<< FRAC_BITS;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      drain_q        <= 1'b0;
      prod_q         <= '0;
      prod_valid_q   <= 1'b0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      drain_q        <= drain_d;
      prod_q         <= prod_d;
      prod_valid_q   <= prod_valid_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_preactivation_mac.sv
// ============================================================================
// tb_gate_preactivation_mac : directed bench for gate_preactivation_mac with
// NUM_ELEMS=4 and hand-computed expected results.               Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gate_preactivation_mac;

  localparam int BW = 18;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [BW-1:0] bias = '0;
  logic          elem_valid = 1'b0;
  logic [BW-1:0] weight = '0;
  logic [BW-1:0] operand_x = '0;
  logic          busy;
  logic [BW-1:0] result;
  logic          result_valid;

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int cnt_snap;
  logic [BW-1:0] exp_hold = '0;
  logic [3:0][BW-1:0] wv;
  logic [3:0][BW-1:0] xv;

  gate_preactivation_mac #(
    .BITWIDTH (18),
    .FRAC_BITS(12),
    .NUM_ELEMS(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .bias        (bias),
    .elem_valid  (elem_valid),
    .weight      (weight),
    .operand_x   (operand_x),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (result_valid) valid_cnt <= valid_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts a dot product (start sampled on the next edge), streams four
  // elements with optional gaps, and returns in the result_valid cycle.
  task automatic run_dot(input string tag, input logic [BW-1:0] b,
                         input logic [3:0][BW-1:0] w, input logic [3:0][BW-1:0] x,
                         input bit gaps, input bit poke, input logic [BW-1:0] exp_res);
    start = 1'b1;
    bias  = b;
    tick();
    start = 1'b0;
    bias  = 18'h15555;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "_result_held"}, 32'(result), 32'(exp_hold));
    for (int i = 0; i < 4; i++) begin
      if (poke && i == 2) begin
        elem_valid = 1'b0;
        start      = 1'b1;
        bias       = 18'h1F000;
        tick();
        start      = 1'b0;
        check({tag, "_busy_ignores_start"}, 32'(busy), 32'd1);
      end
      if (gaps) begin
        for (int g = 0; g < i; g++) begin
          elem_valid = 1'b0;
          weight     = 18'h2AAAA;
          operand_x  = 18'h2AAAA;
          tick();
        end
      end
      elem_valid = 1'b1;
      weight     = w[i];
      operand_x  = x[i];
      tick();
    end
    elem_valid = 1'b0;
    weight     = '0;
    operand_x  = '0;
    tick();
    check({tag, "_valid_edge1"}, 32'(result_valid), 32'd0);
    tick();
    check({tag, "_valid_edge2"}, 32'(result_valid), 32'd0);
    tick();
    check({tag, "_valid_edge3"}, 32'(result_valid), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_busy_low_at_valid"}, 32'(busy), 32'd0);
    exp_hold = exp_res;
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_valid", 32'(result_valid), 32'd0);

    // 0.5 + 4 * (1.0 * 1.0) = 4.5
    for (int i = 0; i < 4; i++) begin
      wv[i] = 18'h01000;
      xv[i] = 18'h01000;
    end
    run_dot("t1", 18'h00800, wv, xv, 1'b0, 1'b0, 18'h04800);
    tick();
    check("t1_single_pulse", 32'(result_valid), 32'd0);
    check("t1_result_stable", 32'(result), 32'h04800);

    run_dot("t2_gaps", 18'h00800, wv, xv, 1'b1, 1'b0, 18'h04800);
    tick();
    check("t2_single_pulse", 32'(result_valid), 32'd0);

    // Positive saturation, then a chained start in the result_valid cycle
    // into negative saturation.
    for (int i = 0; i < 4; i++) begin
      wv[i] = 18'h1FFFF;
      xv[i] = 18'h1FFFF;
    end
    run_dot("t3_pos_sat", 18'h00000, wv, xv, 1'b0, 1'b0, 18'h1FFFF);
    for (int i = 0; i < 4; i++) begin
      wv[i] = 18'h20000;
      xv[i] = 18'h1FFFF;
    end
    run_dot("t3_neg_sat", 18'h00000, wv, xv, 1'b0, 1'b0, 18'h20000);
    tick();
    check("t3_single_pulse", 32'(result_valid), 32'd0);

    // -1 LSB * 0.5 = -0.5 LSB floors to -1 LSB
    wv = '0;
    xv = '0;
    wv[0] = 18'h3FFFF;
    xv[0] = 18'h00800;
    run_dot("t4_floor", 18'h00000, wv, xv, 1'b0, 1'b0, 18'h3FFFF);
    tick();

    // Elements offered in IDLE are ignored; start while busy is ignored.
    elem_valid = 1'b1;
    weight     = 18'h01000;
    operand_x  = 18'h01000;
    tick();
    tick();
    tick();
    elem_valid = 1'b0;
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_result", 32'(result), 32'h3FFFF);
    check("t5_idle_valid", 32'(result_valid), 32'd0);
    cnt_snap = valid_cnt;
    for (int i = 0; i < 4; i++) begin
      wv[i] = 18'h01000;
      xv[i] = 18'h01000;
    end
    run_dot("t5_poke", 18'h00800, wv, xv, 1'b0, 1'b1, 18'h04800);
    tick();
    check("t5_valid_count", 32'(valid_cnt - cnt_snap), 32'd1);

    // Reset mid-stream aborts silently.
    start = 1'b1;
    bias  = 18'h00800;
    tick();
    start = 1'b0;
    elem_valid = 1'b1;
    weight     = 18'h01000;
    operand_x  = 18'h01000;
    tick();
    tick();
    elem_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hold = '0;
    check("t6_reset_busy", 32'(busy), 32'd0);
    check("t6_reset_result", 32'(result), 32'd0);
    check("t6_reset_valid", 32'(result_valid), 32'd0);
    cnt_snap = valid_cnt;
    for (int i = 0; i < 6; i++) tick();
    check("t6_no_valid_after_abort", 32'(valid_cnt - cnt_snap), 32'd0);
    run_dot("t6_rerun", 18'h00800, wv, xv, 1'b0, 1'b0, 18'h04800);
    tick();
    check("t6_single_pulse", 32'(result_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
